// File: rtl/play_scheduler_if.sv
// Control/status bundle between the audio register/FIFO side and the playback scheduler.
// The master side drives the play controls and FIFO level; the slave side returns the strobes and status.
interface play_scheduler_if #(
    parameter int FIFO_AW = 4,
    parameter int RATE_W  = 16,
    parameter int CNT_W   = 8
);
    logic               play_in;
    logic               clr_in;
    logic [RATE_W-1:0]  rate_div_in;
    logic [FIFO_AW:0]   fifo_level_in;
    logic               irq_ack_in;
    logic               tick_out;
    logic               pop_out;
    logic               underrun_out;
    logic [CNT_W-1:0]   underrun_cnt_out;
    logic               irq_req_out;
    logic               busy_out;

    modport master (
        output play_in, clr_in, rate_div_in, fifo_level_in, irq_ack_in,
        input  tick_out, pop_out, underrun_out, underrun_cnt_out, irq_req_out, busy_out
    );

    modport slave (
        input  play_in, clr_in, rate_div_in, fifo_level_in, irq_ack_in,
        output tick_out, pop_out, underrun_out, underrun_cnt_out, irq_req_out, busy_out
    );
endinterface

// File: rtl/play_scheduler.sv
// Sample-rate tick/pop sequencer with underrun counting and a low-FIFO interrupt request.
// All outputs registered; the first tick lands max(rate,2) cycles after entering RUN; no backpressure.
module play_scheduler #(
    parameter int FIFO_AW       = 4,
    parameter int RATE_W        = 16,
    parameter int CNT_W         = 8,
    parameter int PRIME_LEVEL   = 2,
    parameter int IRQ_THRESHOLD = 8
) (
    input logic              clk,
    input logic              rst,
    play_scheduler_if.slave  sif
);
    localparam logic [FIFO_AW:0] PRIME_LVL = (FIFO_AW+1)'(PRIME_LEVEL);
    localparam logic [FIFO_AW:0] IRQ_LVL   = (FIFO_AW+1)'(IRQ_THRESHOLD);

    typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;

    state_t             state_q, state_d;
    logic [RATE_W-1:0]  cnt_q, cnt_d;
    logic [RATE_W-1:0]  load_val;
    logic               tick_d;
    logic               armed_q;
    logic               level_empty;
    logic               level_low;
    logic               set_cond;

    // Periods shorter than two cycles are clamped so tick/pop never merge.
    assign load_val    = (sif.rate_div_in < RATE_W'(2)) ? RATE_W'(1)
                                                        : sif.rate_div_in - RATE_W'(1);
    assign level_empty = (sif.fifo_level_in == '0);
    assign level_low   = (sif.fifo_level_in <= IRQ_LVL);
    assign set_cond    = armed_q && (state_q == RUN) && level_low;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tick_d  = 1'b0;
        if (sif.clr_in) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (sif.play_in) state_d = PRIME;
                end
                PRIME: begin
                    if (!sif.play_in) begin
                        state_d = IDLE;
                    end else if (sif.fifo_level_in >= PRIME_LVL) begin
                        state_d = RUN;
                        cnt_d   = load_val;
                    end
                end
                RUN: begin
                    if (cnt_q == '0) begin
                        // A stop request only takes effect at the period boundary.
                        tick_d = 1'b1;
                        cnt_d  = load_val;
                        if (!sif.play_in) state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q - RATE_W'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q              <= IDLE;
            cnt_q                <= '0;
            armed_q              <= 1'b1;
            sif.tick_out         <= 1'b0;
            sif.pop_out          <= 1'b0;
            sif.underrun_out     <= 1'b0;
            sif.underrun_cnt_out <= '0;
            sif.irq_req_out      <= 1'b0;
            sif.busy_out         <= 1'b0;
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            sif.tick_out     <= tick_d;
            sif.pop_out      <= tick_d && !level_empty;
            sif.underrun_out <= tick_d && level_empty;
            sif.busy_out     <= (state_d != IDLE);
            if (sif.clr_in) begin
                sif.underrun_cnt_out <= '0;
                sif.irq_req_out      <= 1'b0;
                armed_q              <= 1'b1;
            end else begin
                if (tick_d && level_empty && (sif.underrun_cnt_out != '1))
                    sif.underrun_cnt_out <= sif.underrun_cnt_out + CNT_W'(1);
                // Ack beats a coincident set; the set still disarms.
                if (sif.irq_ack_in)
                    sif.irq_req_out <= 1'b0;
                else if (set_cond)
                    sif.irq_req_out <= 1'b1;
                if (set_cond)
                    armed_q <= 1'b0;
                else if (!level_low)
                    armed_q <= 1'b1;
            end
        end
    end
endmodule
